pcmfm_trellis_mod: RTL

PCMFM_TRELLIS_MOD -- requirements
Module: pcmfm_trellis_mod

---
 rtl/pcmfm_pkg.sv | 33 +++
 rtl/pcmfm_trellis_mod_if.sv | 24 ++
 rtl/pcmfm_phase_lut.sv | 19 +
 rtl/pcmfm_trellis_mod.sv | 112 +++++++++++
 4 files changed

// File: rtl/pcmfm_pkg.sv
// Shared constants and types for the PCM/FM trellis modulator:
// 20-point I/Q constellation, phase modulus and sample-phase state type.
package pcmfm_pkg;

  localparam int unsigned PH_MOD = 20;

  typedef enum logic {
    SAMP0 = 1'b0,
    SAMP1 = 1'b1
  } state_t;

  // Point k sits at -18k degrees on a circle of radius 511.
  localparam logic [9:0] COS_TAB [PH_MOD] = '{
    10'h1FF, 10'h1E6, 10'h19D, 10'h12C, 10'h09E,
    10'h000, 10'h362, 10'h2D4, 10'h263, 10'h21A,
    10'h201, 10'h21A, 10'h263, 10'h2D4, 10'h362,
    10'h000, 10'h09E, 10'h12C, 10'h19D, 10'h1E6
  };

  localparam logic [9:0] SIN_TAB [PH_MOD] = '{
    10'h000, 10'h362, 10'h2D4, 10'h263, 10'h21A,
    10'h201, 10'h21A, 10'h263, 10'h2D4, 10'h362,
    10'h000, 10'h09E, 10'h12C, 10'h19D, 10'h1E6,
    10'h1FF, 10'h1E6, 10'h19D, 10'h12C, 10'h09E
  };

  function automatic logic [4:0] phase_add(input logic [4:0] p, input logic [4:0] s);
    logic [5:0] sum;
    sum = {1'b0, p} + {1'b0, s};
    return (sum >= 6'(PH_MOD)) ? 5'(sum - 6'(PH_MOD)) : sum[4:0];
  endfunction

endpackage

// File: rtl/pcmfm_trellis_mod_if.sv
// Bit-input handshake and I/Q sample output bundle for pcmfm_trellis_mod.
interface pcmfm_trellis_mod_if;
  logic       ena;
  logic       bitIn;
  logic       bitValid;
  logic       bitReady;
  logic [9:0] iOut;
  logic [9:0] qOut;
  logic       outValid;
  logic       sampleIdx;
  logic [4:0] phaseIdx;
  logic       underflow;
  logic       clrUnderflow;

  modport master (
    output ena, bitIn, bitValid, clrUnderflow,
    input  bitReady, iOut, qOut, outValid, sampleIdx, phaseIdx, underflow
  );

  modport slave (
    input  ena, bitIn, bitValid, clrUnderflow,
    output bitReady, iOut, qOut, outValid, sampleIdx, phaseIdx, underflow
  );
endinterface

// File: rtl/pcmfm_phase_lut.sv
// Combinational phase-index to I/Q constellation lookup.
module pcmfm_phase_lut
  import pcmfm_pkg::*;
(
  input  logic [4:0] phase,
  output logic [9:0] i_val,
  output logic [9:0] q_val
);

  always_comb begin
    i_val = '0;
    q_val = '0;
    if (phase < 5'(PH_MOD)) begin
      i_val = COS_TAB[phase];
      q_val = SIN_TAB[phase];
    end
  end

endmodule

// File: rtl/pcmfm_trellis_mod.sv
// PCM/FM trellis modulator: two samples per symbol, phase steps mod 20.
// Define PCMFM_NRZM_EN for NRZ-M differential direction coding (default NRZ-L).
module pcmfm_trellis_mod
  import pcmfm_pkg::*;
#(
  parameter int unsigned PH_STEP0 = 4,
  parameter int unsigned PH_STEP1 = 3
) (
  input logic                clk,
  input logic                reset,
  pcmfm_trellis_mod_if.slave bus
);

  localparam logic [4:0] S0_FWD = 5'(PH_STEP0 % PH_MOD);
  localparam logic [4:0] S0_REV = 5'((PH_MOD - (PH_STEP0 % PH_MOD)) % PH_MOD);
  localparam logic [4:0] S1_FWD = 5'(PH_STEP1 % PH_MOD);
  localparam logic [4:0] S1_REV = 5'((PH_MOD - (PH_STEP1 % PH_MOD)) % PH_MOD);

  state_t     state, state_next;
  logic [4:0] phase, phase_next;
  logic       full, held;
  logic       dir, dir_next;
  logic       stepping, stepping_next;
  logic       consume, uf_set, cur_dir;
  logic [9:0] lut_i, lut_q;

  assign bus.bitReady = ~full & ~reset;
  assign bus.phaseIdx = phase;

`ifdef PCMFM_NRZM_EN
  logic level;
  assign cur_dir = level ^ held;
  always_ff @(posedge clk) begin
    if (reset)        level <= 1'b0;
    else if (consume) level <= cur_dir;
  end
`else
  assign cur_dir = held;
`endif

  // SAMP1 only steps when SAMP0 of the same symbol actually consumed a bit.
  always_comb begin
    state_next    = state;
    phase_next    = phase;
    dir_next      = dir;
    stepping_next = stepping;
    consume       = 1'b0;
    uf_set        = 1'b0;
    if (bus.ena) begin
      case (state)
        SAMP0: begin
          state_next = SAMP1;
          if (full) begin
            consume       = 1'b1;
            dir_next      = cur_dir;
            stepping_next = 1'b1;
            phase_next    = phase_add(phase, cur_dir ? S0_FWD : S0_REV);
          end else begin
            uf_set        = 1'b1;
            stepping_next = 1'b0;
          end
        end
        SAMP1: begin
          state_next = SAMP0;
          if (stepping) phase_next = phase_add(phase, dir ? S1_FWD : S1_REV);
        end
      endcase
    end
  end

  pcmfm_phase_lut u_lut (
    .phase (phase_next),
    .i_val (lut_i),
    .q_val (lut_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SAMP0;
      phase         <= '0;
      dir           <= 1'b0;
      stepping      <= 1'b0;
      full          <= 1'b0;
      held          <= 1'b0;
      bus.underflow <= 1'b0;
      bus.iOut      <= 10'h1FF;
      bus.qOut      <= '0;
      bus.outValid  <= 1'b0;
      bus.sampleIdx <= 1'b0;
    end else begin
      state    <= state_next;
      phase    <= phase_next;
      dir      <= dir_next;
      stepping <= stepping_next;
      if (consume) begin
        full <= 1'b0;
      end else if (bus.bitValid && bus.bitReady) begin
        full <= 1'b1;
        held <= bus.bitIn;
      end
      if (uf_set)                bus.underflow <= 1'b1;
      else if (bus.clrUnderflow) bus.underflow <= 1'b0;
      bus.outValid <= bus.ena;
      if (bus.ena) begin
        bus.iOut      <= lut_i;
        bus.qOut      <= lut_q;
        bus.sampleIdx <= (state == SAMP1);
      end
    end
  end

endmodule
